pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program counter with a hardware return-address stack (RAS), replacing the fixed 16-bit PC in the instruction-fetch stage. It supports sequential, absolute-jump, BEQ, BNEQ, CALL and RETURN, plus stall and roll-over. It drives the instruction-memory address every cycle; the decoder supplies the op and immediate, and the ALU supplies the equality flag.

## Interface
Parameters:
- ADDR_W, 16, width of the PC / instruction address
- OFF_W, 15, width of the signed branch offset field (load_data)
- ABS_W, 12, low bits replaced by an absolute jump/call target (ABS_W+1 <= ADDR_W, ABS_W <= OFF_W)
- RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)
- RESET_ADDR, 0, PC value after reset and roll-over

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and stack this cycle
- roll_over  in  1  force PC to RESET_ADDR and empty the stack
- jump_op  in  3  operation select (encodings below)
- eq_flag  in  1  ALU equality result for the current instruction
- load_data  in  OFF_W  signed offset, or absolute target in bits [ABS_W-1:0]
- addr_out  out  ADDR_W  current PC (registered)
- ras_count  out  clog2(RAS_DEPTH)+1  valid stack entries
- ras_overflow  out  1  one-cycle pulse: a push overwrote the oldest entry
- ras_underflow  out  1  one-cycle pulse: RETURN issued with an empty stack
- illegal_op  out  1  one-cycle pulse: reserved jump_op seen

## Operation
- Opcodes: 000 SEQ, 001 JMP, 010 BEQ, 011 BNEQ, 100 CALL, 101 RET, 110/111 reserved.
- seq = addr_out + 1, modulo 2^ADDR_W.
- abs = {addr_out[ADDR_W-1:ABS_W+1], load_data[ABS_W-1:0], 1'b0}.
- rel = addr_out + sign_extend({load_data, 1'b0}) to ADDR_W, modulo 2^ADDR_W. Offset is in half-word units and is always sign-extended, never zero-extended.
- SEQ: addr_out <= seq.
- JMP: addr_out <= abs.
- BEQ: addr_out <= eq_flag ? rel : seq.
- BNEQ: addr_out <= eq_flag ? seq : rel.
- CALL: push seq onto the RAS, then addr_out <= abs.
  - If the stack is full, the push overwrites the oldest entry (circular), ras_count stays RAS_DEPTH, and ras_overflow pulses.
- RET, stack non-empty: pop; addr_out <= popped value; ras_count decrements.
- RET, stack empty: addr_out <= seq; ras_underflow pulses; the stack is unchanged.
- Reserved opcode: behaves as SEQ; illegal_op pulses.
- Priority, evaluated each rising edge: rst_n low > roll_over > stall > jump_op.
  - roll_over: addr_out <= RESET_ADDR, ras_count <= 0, all pulses 0. stall is ignored.
  - stall (without roll_over): all state holds; pulses 0; jump_op and eq_flag are ignored.
- Stack is LIFO. Entry contents beyond ras_count are don't-care and are never observable on addr_out.

## Timing
- Reset (rst_n low, asynchronous): addr_out = RESET_ADDR, ras_count = 0, ras_overflow = ras_underflow = illegal_op = 0. Reset is released synchronously at the first clk edge with rst_n high.
- All outputs are registered and none is combinational from any input.
- addr_out reflects the op sampled at edge N immediately after edge N, i.e. one-cycle latency.
- Pulses are asserted for exactly the one cycle following the causing edge, aligned with the corresponding addr_out update.
- Back-to-back CALL/RET on consecutive cycles is supported with no bubble. A RET directly after a CALL returns the address pushed by that CALL.
- Reset asserted mid-operation empties the stack immediately. No pending push or pop survives.

## Structure
- Shared package holds: the jump_op encodings (OP_SEQ … OP_RET), the RAS count-width function, and ADDR_W/OFF_W defaults shared with the decoder.
- One sub-module, ras_stack: circular buffer holding RAS_DEPTH entries of ADDR_W bits, with a top pointer and a count. Ports: push, pop, push_data, top_data, count, ovf.
- The top level holds the PC register, the next-PC mux, and the pulse flops.

## Test plan
- Reset and SEQ: hold rst_n low, then release. addr_out = 0, then 1, 2, 3 on successive edges. At ADDR_W=16, from 0xFFFF the next SEQ gives 0x0000.
- Branches: from PC 0x0010, BEQ with eq_flag=1 and load_data=0x7FFE (-2) gives 0x000C. BNEQ with eq_flag=1 gives 0x0011. BEQ with eq_flag=0 and load_data=0x0004 gives 0x0011.
- JMP/CALL/RET: from PC 0xE020, CALL with load_data=0x0ABC gives 0xF578 and ras_count=1. RET then gives 0xE021 and ras_count=0.
- Overflow/underflow at RAS_DEPTH=4: five nested CALLs assert ras_overflow on the 5th with ras_count=4. Five RETs return the last four pushed addresses in reverse order. The 5th RET gives seq and asserts ras_underflow.
- Priority: stall=1 with CALL leaves PC and ras_count unchanged. roll_over=1 with stall=1 gives addr_out=RESET_ADDR and ras_count=0. rst_n dropped between clock edges clears outputs without waiting for an edge.
- Reserved op 3'b110 from PC 0x0040 gives 0x0041, and illegal_op pulses for exactly one cycle.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared definitions for the instruction-fetch program counter and its
//   decoder: jump_op encodings, default address/offset widths and the
//   width helper for the return-address stack occupancy count.
package pc_sequencer_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int OFF_W_DEF  = 15;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000,
        OP_JMP  = 3'b001,
        OP_BEQ  = 3'b010,
        OP_BNEQ = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_e;

    // Count must represent 0..depth inclusive, hence one bit above the pointer.
    function automatic int ras_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Fetch-stage bus between the decoder/ALU side and the program counter.
//   jump_op   : operation select from the decoder
//   eq_flag   : ALU equality result for the current instruction
//   load_data : signed half-word offset, or absolute target in the low bits
//   addr_out  : current PC, driven by the sequencer to instruction memory
//   Modports: master = decoder side, slave = pc_sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int OFF_W  = 15
) ();
    logic [2:0]        jump_op;
    logic              eq_flag;
    logic [OFF_W-1:0]  load_data;
    logic [ADDR_W-1:0] addr_out;

    modport master (output jump_op, output eq_flag, output load_data, input addr_out);
    modport slave  (input jump_op, input eq_flag, input load_data, output addr_out);
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack
//   Circular return-address stack. A push into a full stack silently
//   overwrites the oldest entry; the count saturates at RAS_DEPTH.
//   clk, rst_n : clock, asynchronous active-low reset (empties the stack)
//   clr        : synchronous empty (roll-over), dominates push/pop
//   push, pop  : single-cycle requests; never asserted together
//   push_data  : address to push
//   top_data   : most recently pushed entry (valid when count != 0)
//   count      : number of valid entries
//   ovf        : push this cycle would overwrite the oldest entry
module ras_stack
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RAS_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            push,
    input  logic                            pop,
    input  logic [ADDR_W-1:0]               push_data,
    output logic [ADDR_W-1:0]               top_data,
    output logic [ras_cnt_w(RAS_DEPTH)-1:0] count,
    output logic                            ovf
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = ras_cnt_w(RAS_DEPTH);

    // Points at the next slot to write; wraps naturally (depth is a power of two).
    logic [PTR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic              full;

    assign full     = (count == CNT_W'(RAS_DEPTH));
    assign ovf      = push && full;
    assign top_data = mem[wr_ptr - PTR_W'(1)];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full) count <= count + CNT_W'(1);
        end else if (pop && count != '0) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
            count  <= count - CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; entries beyond count are never
    // read, so clearing them would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-stage program counter with hardware return-address stack.
//   Supports SEQ, JMP, BEQ, BNEQ, CALL, RET; stall holds everything,
//   roll_over returns to RESET_ADDR and empties the stack.
//   clk, rst_n    : clock, asynchronous active-low reset
//   stall         : hold PC and stack this cycle
//   roll_over     : force PC to RESET_ADDR, empty the stack
//   fetch         : decoder/ALU bus (jump_op, eq_flag, load_data in; addr_out out)
//   ras_count     : valid stack entries
//   ras_overflow  : pulse, a CALL overwrote the oldest stack entry
//   ras_underflow : pulse, RET issued with an empty stack
//   illegal_op    : pulse, reserved jump_op executed as SEQ
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              ADDR_W     = ADDR_W_DEF,
    parameter int              OFF_W      = OFF_W_DEF,
    parameter int              ABS_W      = 12,
    parameter int              RAS_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            stall,
    input  logic                            roll_over,
    pc_sequencer_if.slave                   fetch,
    output logic [ras_cnt_w(RAS_DEPTH)-1:0] ras_count,
    output logic                            ras_overflow,
    output logic                            ras_underflow,
    output logic                            illegal_op
);
    // Bits [ABS_W:0] are replaced by an absolute target; the rest come from the PC.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << (ABS_W + 1)) - 64'd1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] seq_pc, abs_pc, rel_pc, rel_off, next_pc;
    logic [ADDR_W-1:0] abs_low, top_data;
    logic [OFF_W:0]    off_raw;
    logic              push_req, pop_req, unf_next, ill_next;
    logic              advance, stack_ovf;

    assign seq_pc  = pc_q + ADDR_W'(1);
    assign abs_low = ADDR_W'({fetch.load_data[ABS_W-1:0], 1'b0});
    assign abs_pc  = (pc_q & ~LOW_MASK) | abs_low;

    // Offset is in half-words and always sign-extended to the PC width.
    assign off_raw = {fetch.load_data, 1'b0};
    if (OFF_W + 1 >= ADDR_W) begin : g_off_trunc
        assign rel_off = off_raw[ADDR_W-1:0];
    end else begin : g_off_sext
        assign rel_off = ADDR_W'($signed(off_raw));
    end
    assign rel_pc = pc_q + rel_off;

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    always_comb begin
        next_pc  = seq_pc;
        push_req = 1'b0;
        pop_req  = 1'b0;
        unf_next = 1'b0;
        ill_next = 1'b0;
        case (fetch.jump_op)
            OP_SEQ:  next_pc = seq_pc;
            OP_JMP:  next_pc = abs_pc;
            OP_BEQ:  if (fetch.eq_flag)  next_pc = rel_pc;
            OP_BNEQ: if (!fetch.eq_flag) next_pc = rel_pc;
            OP_CALL: begin
                push_req = 1'b1;
                next_pc  = abs_pc;
            end
            OP_RET: begin
                if (ras_count == '0) begin
                    unf_next = 1'b1;
                end else begin
                    pop_req = 1'b1;
                    next_pc = top_data;
                end
            end
            default: ill_next = 1'b1;
        endcase
    end

    // roll_over outranks stall; either one blocks the stack from moving.
    assign advance = !roll_over && !stall;

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (roll_over),
        .push      (push_req && advance),
        .pop       (pop_req && advance),
        .push_data (seq_pc),
        .top_data  (top_data),
        .count     (ras_count),
        .ovf       (stack_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_ADDR;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            illegal_op    <= 1'b0;
        end else if (roll_over) begin
            pc_q          <= RESET_ADDR;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            illegal_op    <= 1'b0;
        end else if (stall) begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            illegal_op    <= 1'b0;
        end else begin
            pc_q          <= next_pc;
            ras_overflow  <= stack_ovf;
            ras_underflow <= unf_next;
            illegal_op    <= ill_next;
        end
    end

    assign fetch.addr_out = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed vectors with hand-computed results. The stimulus side pushes
//   the expected post-edge state into a queue; a monitor compares after
//   every rising edge. Default parameters: ADDR_W=16, OFF_W=15, ABS_W=12,
//   RAS_DEPTH=4, RESET_ADDR=0.
module tb_pc_sequencer;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
        logic        ill;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall;
    logic       roll_over;
    logic [2:0] ras_count;
    logic       ras_overflow, ras_underflow, illegal_op;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_sequencer_if #(.ADDR_W(16), .OFF_W(15)) bus ();

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .roll_over     (roll_over),
        .fetch         (bus),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one operation at the falling edge; its result is due after the next rising edge.
    task automatic step(input logic [2:0] op, input logic eq, input logic [14:0] ld,
                        input logic stl, input logic rol, input logic [15:0] ea,
                        input logic [2:0] ec, input logic eo, input logic eu,
                        input logic ei, input string nm);
        exp_t e;
        @(negedge clk);
        bus.jump_op   = op;
        bus.eq_flag   = eq;
        bus.load_data = ld;
        stall         = stl;
        roll_over     = rol;
        e.addr = ea; e.cnt = ec; e.ovf = eo; e.unf = eu; e.ill = ei; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Park the DUT on stall and wait (bounded) for the monitor to consume everything.
    task automatic drain();
        @(negedge clk);
        stall       = 1'b1;
        roll_over   = 1'b0;
        bus.jump_op = 3'b000;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare one expected entry after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({e.name, ".addr"}, 32'(bus.addr_out), 32'(e.addr));
                check({e.name, ".cnt"},  32'(ras_count),    32'(e.cnt));
                check({e.name, ".ovf"},  32'(ras_overflow), 32'(e.ovf));
                check({e.name, ".unf"},  32'(ras_underflow), 32'(e.unf));
                check({e.name, ".ill"},  32'(illegal_op),   32'(e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b1;
        roll_over     = 1'b0;
        bus.jump_op   = 3'b000;
        bus.eq_flag   = 1'b0;
        bus.load_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.addr", 32'(bus.addr_out), 32'h0);
        check("reset.cnt",  32'(ras_count),    32'h0);
        check("reset.pulses", 32'({ras_overflow, ras_underflow, illegal_op}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //    op      eq    ld        stl   rol   addr      cnt   ovf   unf   ill   name
        step(3'b000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0001, 3'd0, 1'b0, 1'b0, 1'b0, "seq1");
        step(3'b000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0002, 3'd0, 1'b0, 1'b0, 1'b0, "seq2");
        step(3'b000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0003, 3'd0, 1'b0, 1'b0, 1'b0, "seq3");
        step(3'b010, 1'b1, 15'h7FFE, 1'b0, 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0, "beq_back_wrap");
        step(3'b000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, "seq_rollover");
        step(3'b001, 1'b0, 15'h0008, 1'b0, 1'b0, 16'h0010, 3'd0, 1'b0, 1'b0, 1'b0, "jmp_10a");
        step(3'b010, 1'b1, 15'h7FFE, 1'b0, 1'b0, 16'h000C, 3'd0, 1'b0, 1'b0, 1'b0, "beq_taken_neg");
        step(3'b001, 1'b0, 15'h0008, 1'b0, 1'b0, 16'h0010, 3'd0, 1'b0, 1'b0, 1'b0, "jmp_10b");
        step(3'b011, 1'b1, 15'h7FFE, 1'b0, 1'b0, 16'h0011, 3'd0, 1'b0, 1'b0, 1'b0, "bneq_not_taken");
        step(3'b001, 1'b0, 15'h0008, 1'b0, 1'b0, 16'h0010, 3'd0, 1'b0, 1'b0, 1'b0, "jmp_10c");
        step(3'b010, 1'b0, 15'h0004, 1'b0, 1'b0, 16'h0011, 3'd0, 1'b0, 1'b0, 1'b0, "beq_not_taken");
        step(3'b011, 1'b0, 15'h0004, 1'b0, 1'b0, 16'h0019, 3'd0, 1'b0, 1'b0, 1'b0, "bneq_taken_pos");
        step(3'b000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h001A, 3'd0, 1'b0, 1'b0, 1'b0, "seq_1a");
        step(3'b010, 1'b1, 15'h7003, 1'b0, 1'b0, 16'hE020, 3'd0, 1'b0, 1'b0, 1'b0, "beq_far");
        // CALL then RET back-to-back
        step(3'b100, 1'b0, 15'h0ABC, 1'b0, 1'b0, 16'hF578, 3'd1, 1'b0, 1'b0, 1'b0, "call_abs");
        step(3'b101, 1'b0, 15'h0000, 1'b0, 1'b0, 16'hE021, 3'd0, 1'b0, 1'b0, 1'b0, "ret_b2b");
        // Five nested calls into a four-entry stack
        step(3'b100, 1'b0, 15'h0100, 1'b0, 1'b0, 16'hE200, 3'd1, 1'b0, 1'b0, 1'b0, "call1");
        step(3'b100, 1'b0, 15'h0200, 1'b0, 1'b0, 16'hE400, 3'd2, 1'b0, 1'b0, 1'b0, "call2");
        step(3'b100, 1'b0, 15'h0300, 1'b0, 1'b0, 16'hE600, 3'd3, 1'b0, 1'b0, 1'b0, "call3");
        step(3'b100, 1'b0, 15'h0400, 1'b0, 1'b0, 16'hE800, 3'd4, 1'b0, 1'b0, 1'b0, "call4");
        step(3'b100, 1'b0, 15'h0500, 1'b0, 1'b0, 16'hEA00, 3'd4, 1'b1, 1'b0, 1'b0, "call5_ovf");
        step(3'b101, 1'b0, 15'h0000, 1'b0, 1'b0, 16'hE801, 3'd3, 1'b0, 1'b0, 1'b0, "ret1");
        step(3'b101, 1'b0, 15'h0000, 1'b0, 1'b0, 16'hE601, 3'd2, 1'b0, 1'b0, 1'b0, "ret2");
        step(3'b101, 1'b0, 15'h0000, 1'b0, 1'b0, 16'hE401, 3'd1, 1'b0, 1'b0, 1'b0, "ret3");
        step(3'b101, 1'b0, 15'h0000, 1'b0, 1'b0, 16'hE201, 3'd0, 1'b0, 1'b0, 1'b0, "ret4");
        step(3'b101, 1'b0, 15'h0000, 1'b0, 1'b0, 16'hE202, 3'd0, 1'b0, 1'b1, 1'b0, "ret5_unf");
        step(3'b000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'hE203, 3'd0, 1'b0, 1'b0, 1'b0, "seq_after_unf");
        // Stall and roll-over priority
        step(3'b100, 1'b0, 15'h0100, 1'b0, 1'b0, 16'hE200, 3'd1, 1'b0, 1'b0, 1'b0, "call_pre_stall");
        step(3'b100, 1'b0, 15'h0300, 1'b1, 1'b0, 16'hE200, 3'd1, 1'b0, 1'b0, 1'b0, "stall_call");
        step(3'b101, 1'b0, 15'h0000, 1'b1, 1'b0, 16'hE200, 3'd1, 1'b0, 1'b0, 1'b0, "stall_ret");
        step(3'b101, 1'b0, 15'h0000, 1'b0, 1'b0, 16'hE204, 3'd0, 1'b0, 1'b0, 1'b0, "ret_after_stall");
        step(3'b100, 1'b0, 15'h0100, 1'b0, 1'b0, 16'hE200, 3'd1, 1'b0, 1'b0, 1'b0, "call_pre_roll");
        step(3'b100, 1'b0, 15'h0300, 1'b1, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, "roll_with_stall");
        step(3'b101, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0001, 3'd0, 1'b0, 1'b1, 1'b0, "ret_after_roll");
        // Reserved opcodes
        step(3'b001, 1'b0, 15'h0020, 1'b0, 1'b0, 16'h0040, 3'd0, 1'b0, 1'b0, 1'b0, "jmp_40");
        step(3'b110, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0041, 3'd0, 1'b0, 1'b0, 1'b1, "illegal_110");
        step(3'b000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0042, 3'd0, 1'b0, 1'b0, 1'b0, "ill_one_cycle");
        step(3'b111, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0043, 3'd0, 1'b0, 1'b0, 1'b1, "illegal_111");
        step(3'b100, 1'b0, 15'h0010, 1'b0, 1'b0, 16'h0020, 3'd1, 1'b0, 1'b0, 1'b0, "call_pre_rst");
        drain();

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst.addr", 32'(bus.addr_out), 32'h0);
        check("async_rst.cnt",  32'(ras_count),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b101, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0001, 3'd0, 1'b0, 1'b1, 1'b0, "ret_after_rst");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
